// File: rtl/seq_loader.sv
`default_nettype none
// ============================================================================
// Module   : seq_loader
// Turns a captured load word into preset/clear pulse pairs, in parallel or group by group.
// Revision : 1.0
// ============================================================================
module seq_loader #(
    parameter int WIDTH     = 16,
    parameter int PULSE_CYC = 2,
    parameter int GROUPS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 permit,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     values,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int GW  = WIDTH / GROUPS;
    localparam int GIW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW  = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   word_q;
    logic               mode_q;
    logic [GIW-1:0]     g_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] out_q;
    logic               busy_q;
    logic               done_q;

    logic [GIW-1:0]     next_g_d;
    logic [2*WIDTH-1:0] load_pat_d;
    logic [2*WIDTH-1:0] next_pat_d;

    // Inactive bits stay 00; active bits get preset for a 1 and clear for a 0.
    function automatic logic [2*WIDTH-1:0] pairs(input logic [WIDTH-1:0] w,
                                                 input logic staged,
                                                 input logic [GIW-1:0] grp);
        logic [2*WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!staged || ((i / GW) == int'(grp))) begin
                p[2*i+1] = w[i];
                p[2*i]   = ~w[i];
            end
        end
        return p;
    endfunction

    always_comb begin
        next_g_d   = g_q + 1'b1;
        load_pat_d = pairs(values, mode, '0);
        next_pat_d = pairs(word_q, mode_q, next_g_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            mode_q  <= 1'b0;
            g_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (permit) begin
                        word_q  <= values;
                        mode_q  <= mode;
                        g_q     <= '0;
                        cnt_q   <= '0;
                        out_q   <= load_pat_d;
                        busy_q  <= 1'b1;
                        state_q <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == CW'(PULSE_CYC - 1)) begin
                        out_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (mode_q && (g_q < GIW'(GROUPS - 1))) begin
                        g_q     <= next_g_d;
                        cnt_q   <= '0;
                        out_q   <= next_pat_d;
                        state_q <= S_PULSE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_loader
// Self-checking bench for seq_loader against a cycle-schedule reference model.
// Revision : 1.0
// ============================================================================
module tb_seq_loader;

    localparam int W   = 16;
    localparam int P   = 2;
    localparam int G   = 4;
    localparam int GWT = W / G;

    logic           clk;
    logic           rst;
    logic           permit;
    logic           mode;
    logic [W-1:0]   values;
    logic [2*W-1:0] out;
    logic           busy;
    logic           done;

    int total;
    int passed;

    seq_loader #(.WIDTH(W), .PULSE_CYC(P), .GROUPS(G)) dut (
        .clk    (clk),
        .rst    (rst),
        .permit (permit),
        .mode   (mode),
        .values (values),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps after the accepting edge: groups of (P pulse cycles + 1 gap), then done, then idle.
    function automatic int load_len(input bit md);
        return (md ? G : 1) * (P + 1) + 2;
    endfunction

    function automatic logic [2*W+1:0] expect_at(input logic [W-1:0] w, input bit md, input int k);
        int             ng;
        int             per;
        int             grp;
        logic [2*W-1:0] o;
        ng  = md ? G : 1;
        per = P + 1;
        o   = '0;
        if (k < ng * per) begin
            if ((k % per) < P) begin
                grp = k / per;
                for (int i = 0; i < W; i++)
                    if (!md || (i / GWT) == grp)
                        o[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
            end
            return {o, 1'b1, 1'b0};
        end else if (k == ng * per) begin
            return {o, 1'b1, 1'b1};
        end
        return {o, 1'b0, 1'b0};
    endfunction

    task automatic run_load(input string name, input logic [W-1:0] w, input bit md,
                            input bit scramble, input bit keep, input int abort_at);
        int             len;
        logic [2*W+1:0] exp_v;
        logic [2*W+1:0] got;
        len = load_len(md);
        @(negedge clk);
        permit = 1'b1;
        values = w;
        mode   = md;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            exp_v = expect_at(w, md, k);
            got   = {out, busy, done};
            total++;
            if (got !== exp_v)
                $display("FAIL %s step %0d: got out=%h busy=%b done=%b, expected out=%h busy=%b done=%b",
                         name, k, got[2*W+1:2], got[1], got[0], exp_v[2*W+1:2], exp_v[1], exp_v[0]);
            else
                passed++;
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1;
                total++;
                if ({out, busy, done} !== '0)
                    $display("FAIL %s async_reset: got out=%h busy=%b done=%b, expected all zero",
                             name, out, busy, done);
                else
                    passed++;
                return;
            end
            if (scramble) begin
                values = W'($urandom);
                mode   = 1'($urandom);
                permit = (k < len - 1) ? 1'($urandom) : 1'b0;
            end else if (!keep) begin
                permit = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        permit = 1'b0;
        mode   = 1'b0;
        values = '0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out, busy, done} !== '0)
            $display("FAIL reset: got out=%h busy=%b done=%b, expected all zero", out, busy, done);
        else
            passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_parallel();
        run_load("parallel_a5c3", 16'hA5C3, 1'b0, 1'b0, 1'b0, -1);
        for (int n = 0; n < 3; n++)
            run_load("parallel_rand", W'($urandom), 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_staged();
        run_load("staged_a5c3", 16'hA5C3, 1'b1, 1'b0, 1'b0, -1);
        for (int n = 0; n < 2; n++)
            run_load("staged_rand", W'($urandom), 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_ignore_inputs();
        run_load("ignore_inputs", 16'hA5C3, 1'b0, 1'b1, 1'b0, -1);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out, busy, done} !== '0)
                $display("FAIL ignore_idle %0d: got out=%h busy=%b done=%b, expected all zero",
                         n, out, busy, done);
            else
                passed++;
        end
    endtask

    task automatic test_back_to_back();
        run_load("b2b_first", 16'hA5C3, 1'b0, 1'b0, 1'b1, -1);
        run_load("b2b_second", W'($urandom), 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        run_load("reset_mid", 16'hA5C3, 1'b1, 1'b0, 1'b0, 6);
        permit = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({out, busy, done} !== '0)
            $display("FAIL reset_hold: got out=%h busy=%b done=%b, expected all zero", out, busy, done);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        run_load("after_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_parallel();
        test_staged();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
